msx_ram_mapper_ext: RTL and testbench

Parametrised MSX memory-mapper successor for RAM beyond 4 MB. Decodes the four segment-register I/O ports plus an extension port for high segment bits, and translates CPU addresses to RAM addresses. Provides three read-back modes and a RAM-clear engine that sweeps the populated RAM after reset or on request. Sits between the CPU bus decode and the slot/SDRAM arbiter, in the same place as the existing MSX2 mapper.

---
 rtl/msx_mapper_pkg.sv | 22 ++
 rtl/msx_ram_mapper_ext_if.sv | 24 ++
 rtl/msx_mapper_clear.sv | 72 +++++++
 rtl/msx_ram_mapper_ext.sv | 102 ++++++++++
 tb/tb_msx_ram_mapper_ext.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msx_mapper_pkg.sv
// Shared types and defaults for the extended MSX RAM mapper.
package msx_mapper_pkg;

    localparam int unsigned PAGE_W = 14;

    localparam logic [7:0] DEF_IO_BASE  = 8'hFC;
    localparam logic [7:0] DEF_EXT_PORT = 8'hF7;
    localparam int unsigned DEF_SEG_W   = 8;

    typedef enum logic [1:0] {
        RB_OR  = 2'd0,
        RB_RAW = 2'd1,
        RB_FF  = 2'd2
    } rb_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } clr_state_e;

endpackage

// File: rtl/msx_ram_mapper_ext_if.sv
// CPU-side bus of the mapper: I/O decode inputs and translated address / read-back outputs.
interface msx_ram_mapper_ext_if #(
    parameter int unsigned SEG_W = msx_mapper_pkg::DEF_SEG_W
);
    logic                                     cpu_iorq;
    logic                                     cpu_m1;
    logic                                     cpu_wr;
    logic                                     cpu_rd;
    logic [15:0]                              cpu_addr;
    logic [7:0]                               cpu_dout;
    logic [7:0]                               mapper_dout;
    logic                                     mapper_req;
    logic [SEG_W+msx_mapper_pkg::PAGE_W-1:0]  mapper_addr;

    modport master (
        output cpu_iorq, cpu_m1, cpu_wr, cpu_rd, cpu_addr, cpu_dout,
        input  mapper_dout, mapper_req, mapper_addr
    );

    modport slave (
        input  cpu_iorq, cpu_m1, cpu_wr, cpu_rd, cpu_addr, cpu_dout,
        output mapper_dout, mapper_req, mapper_addr
    );
endinterface

// File: rtl/msx_mapper_clear.sv
// RAM-clear engine: walks every populated address once, one acknowledged write at a time.
module msx_mapper_clear
    import msx_mapper_pkg::*;
#(
    parameter int unsigned ADDR_W  = 22,
    parameter bit          INIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W:0]   total,
    input  logic              init_start,
    input  logic              init_ack,
    output logic              init_req,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_busy
);

    clr_state_e        state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W:0]   total_m1;
    logic              boot_pend;
    logic              last;

    assign total_m1 = total - (ADDR_W+1)'(1);
    assign last     = ({1'b0, init_addr} == total_m1);

    // boot_pend is only high for the first clk after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            init_addr <= '0;
            boot_pend <= INIT_EN;
        end else begin
            state     <= state_nxt;
            init_addr <= addr_nxt;
            boot_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = init_addr;
        case (state)
            ST_IDLE: begin
                if (boot_pend || init_start) begin
                    state_nxt = ST_REQ;
                    addr_nxt  = '0;
                end
            end
            ST_REQ: begin
                if (init_ack) begin
                    if (last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        addr_nxt = init_addr + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                addr_nxt  = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign init_req  = (state == ST_REQ);
    assign init_busy = (state != ST_IDLE);

endmodule

// File: rtl/msx_ram_mapper_ext.sv
// MSX memory mapper with high segment bits via an extension port, read-back modes and RAM clear.
module msx_ram_mapper_ext
    import msx_mapper_pkg::*;
#(
    parameter logic [7:0]  IO_BASE     = DEF_IO_BASE,
    parameter logic [7:0]  EXT_PORT    = DEF_EXT_PORT,
    parameter int unsigned SEG_W       = DEF_SEG_W,
    parameter bit          RESET_STYLE = 1'b0,
    parameter bit          INIT_EN     = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    msx_ram_mapper_ext_if.slave       bus,
    input  logic [SEG_W:0]            ram_block_count,
    input  logic [1:0]                readback_mode,
    input  logic                      init_start,
    input  logic                      init_ack,
    output logic                      init_req,
    output logic [SEG_W+PAGE_W-1:0]   init_addr,
    output logic                      init_busy
);

    localparam int unsigned ADDR_W = SEG_W + PAGE_W;
    localparam int unsigned HI_W   = (SEG_W > 8) ? SEG_W - 8 : 1;

    logic             seg_sel, ext_sel;
    logic             seg_wr, ext_wr;
    logic             seg_wr_q, ext_wr_q;
    logic             seg_we, ext_we;
    logic [SEG_W-1:0] seg [4];
    logic [HI_W-1:0]  hi_pend, hi_cur;
    logic             hi_valid;
    logic [SEG_W-1:0] mask, seg_din;
    logic [ADDR_W:0]  total;

    assign seg_sel = bus.cpu_iorq & ~bus.cpu_m1 & (bus.cpu_addr[7:2] == IO_BASE[7:2]);
    assign ext_sel = bus.cpu_iorq & ~bus.cpu_m1 & (bus.cpu_addr[7:0] == EXT_PORT);

    // Rising edge of the qualified strobe commits, so long strobes write once
    assign seg_wr = seg_sel & bus.cpu_wr;
    assign ext_wr = ext_sel & bus.cpu_wr;
    assign seg_we = seg_wr & ~seg_wr_q;
    assign ext_we = (SEG_W > 8) && ext_wr && !ext_wr_q;

    assign hi_cur  = hi_valid ? hi_pend : '0;
    assign seg_din = SEG_W'({hi_cur, bus.cpu_dout});

    // Power-of-two block count; zero wraps to all ones
    assign mask  = SEG_W'(ram_block_count - (SEG_W+1)'(1));
    assign total = (ram_block_count == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                           : {ram_block_count, {PAGE_W{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                seg[i] <= RESET_STYLE ? SEG_W'(3 - i) : '0;
            end
            hi_pend  <= '0;
            hi_valid <= 1'b0;
            seg_wr_q <= 1'b0;
            ext_wr_q <= 1'b0;
        end else begin
            seg_wr_q <= seg_wr;
            ext_wr_q <= ext_wr;
            if (ext_we) begin
                hi_pend  <= bus.cpu_dout[HI_W-1:0];
                hi_valid <= 1'b1;
            end
            if (seg_we) begin
                seg[bus.cpu_addr[1:0]] <= seg_din;
                hi_valid               <= 1'b0;
            end
        end
    end

    assign bus.mapper_addr = {seg[bus.cpu_addr[15:14]] & mask, bus.cpu_addr[13:0]};
    assign bus.mapper_req  = seg_sel & bus.cpu_rd;

    always_comb begin
        bus.mapper_dout = 8'hFF;
        case (readback_mode)
            RB_OR:   bus.mapper_dout = seg[bus.cpu_addr[1:0]][7:0] | ~mask[7:0];
            RB_RAW:  bus.mapper_dout = seg[bus.cpu_addr[1:0]][7:0];
            default: bus.mapper_dout = 8'hFF;
        endcase
    end

    msx_mapper_clear #(
        .ADDR_W  (ADDR_W),
        .INIT_EN (INIT_EN)
    ) u_clear (
        .clk        (clk),
        .reset      (reset),
        .total      (total),
        .init_start (init_start),
        .init_ack   (init_ack),
        .init_req   (init_req),
        .init_addr  (init_addr),
        .init_busy  (init_busy)
    );

endmodule

// File: tb/tb_msx_ram_mapper_ext.sv
// Directed bench for msx_ram_mapper_ext: decode, read-back, extension bits and clear engine.
module tb_msx_ram_mapper_ext;
    import msx_mapper_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ab, rst_c;
    logic [8:0]  cnt_a, cnt_c;
    logic [10:0] cnt_b;
    logic [1:0]  mode_a, mode_b;
    logic        start_c, ack_c;
    logic        req_a, busy_a, req_b, busy_b, req_c, busy_c;
    logic [21:0] iaddr_a, iaddr_c;
    logic [23:0] iaddr_b;

    int errors = 0;
    int checks = 0;
    int commits_a = 0;

    msx_ram_mapper_ext_if #(.SEG_W(8))  bus_a ();
    msx_ram_mapper_ext_if #(.SEG_W(10)) bus_b ();
    msx_ram_mapper_ext_if #(.SEG_W(8))  bus_c ();

    msx_ram_mapper_ext #(.SEG_W(8), .RESET_STYLE(1'b1), .INIT_EN(1'b0)) dut_a (
        .clk(clk), .reset(rst_ab), .bus(bus_a), .ram_block_count(cnt_a),
        .readback_mode(mode_a), .init_start(1'b0), .init_ack(1'b0),
        .init_req(req_a), .init_addr(iaddr_a), .init_busy(busy_a));

    msx_ram_mapper_ext #(.SEG_W(10), .RESET_STYLE(1'b0), .INIT_EN(1'b0)) dut_b (
        .clk(clk), .reset(rst_ab), .bus(bus_b), .ram_block_count(cnt_b),
        .readback_mode(mode_b), .init_start(1'b0), .init_ack(1'b0),
        .init_req(req_b), .init_addr(iaddr_b), .init_busy(busy_b));

    msx_ram_mapper_ext #(.SEG_W(8), .RESET_STYLE(1'b0), .INIT_EN(1'b1)) dut_c (
        .clk(clk), .reset(rst_c), .bus(bus_c), .ram_block_count(cnt_c),
        .readback_mode(2'd0), .init_start(start_c), .init_ack(ack_c),
        .init_req(req_c), .init_addr(iaddr_c), .init_busy(busy_c));

    // Commit probe: seg_we sampled before the edge's nonblocking updates
    always @(posedge clk) if (dut_a.seg_we) commits_a++;

    task automatic io_wr_a(input logic [7:0] port, input logic [7:0] data, input int hold, input logic m1);
        @(negedge clk);
        bus_a.cpu_addr = {8'h00, port}; bus_a.cpu_dout = data;
        bus_a.cpu_m1 = m1; bus_a.cpu_iorq = 1'b1; bus_a.cpu_wr = 1'b1;
        repeat (hold) @(negedge clk);
        bus_a.cpu_iorq = 1'b0; bus_a.cpu_wr = 1'b0; bus_a.cpu_m1 = 1'b0;
    endtask

    task automatic io_wr_b(input logic [7:0] port, input logic [7:0] data);
        @(negedge clk);
        bus_b.cpu_addr = {8'h00, port}; bus_b.cpu_dout = data;
        bus_b.cpu_iorq = 1'b1; bus_b.cpu_wr = 1'b1;
        @(negedge clk);
        bus_b.cpu_iorq = 1'b0; bus_b.cpu_wr = 1'b0;
    endtask

    task automatic test_reset();
        bus_a.cpu_iorq = 0; bus_a.cpu_m1 = 0; bus_a.cpu_wr = 0; bus_a.cpu_rd = 0;
        bus_a.cpu_addr = '0; bus_a.cpu_dout = '0;
        bus_b.cpu_iorq = 0; bus_b.cpu_m1 = 0; bus_b.cpu_wr = 0; bus_b.cpu_rd = 0;
        bus_b.cpu_addr = '0; bus_b.cpu_dout = '0;
        bus_c.cpu_iorq = 0; bus_c.cpu_m1 = 0; bus_c.cpu_wr = 0; bus_c.cpu_rd = 0;
        bus_c.cpu_addr = '0; bus_c.cpu_dout = '0;
        cnt_a = 9'd16; cnt_b = 11'd1024; cnt_c = 9'd1;
        mode_a = 2'd0; mode_b = 2'd0; start_c = 0; ack_c = 0;
        rst_ab = 0; rst_c = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req_c !== 1'b0 || busy_c !== 1'b0 || iaddr_c !== 22'd0) begin
            errors++; $display("FAIL reset_c got req=%b busy=%b addr=%h exp 0 0 0", req_c, busy_c, iaddr_c);
        end
        @(negedge clk); rst_ab = 1;
        @(negedge clk); #1;
        checks++; if (req_a !== 1'b0 || busy_a !== 1'b0 || iaddr_a !== 22'd0) begin
            errors++; $display("FAIL reset_a_clear got req=%b busy=%b addr=%h exp 0 0 0", req_a, busy_a, iaddr_a);
        end
        checks++; if (busy_b !== 1'b0) begin
            errors++; $display("FAIL reset_b_busy got=%b exp=0", busy_b);
        end
        bus_b.cpu_addr = 16'hC000; #1;
        checks++; if (bus_b.mapper_addr !== 24'h000000) begin
            errors++; $display("FAIL reset_b_seg3 got=%h exp=000000", bus_b.mapper_addr);
        end
    endtask

    task automatic test_reset_style();
        logic [7:0] exp_rd [4];
        exp_rd = '{8'hF3, 8'hF2, 8'hF1, 8'hF0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_a.cpu_addr = 16'h00FC + 16'(i); bus_a.cpu_iorq = 1; bus_a.cpu_rd = 1; #1;
            checks++; if (bus_a.mapper_dout !== exp_rd[i] || bus_a.mapper_req !== 1'b1) begin
                errors++; $display("FAIL rd_port%0d got=%h req=%b exp=%h req=1", i, bus_a.mapper_dout, bus_a.mapper_req, exp_rd[i]);
            end
        end
        @(negedge clk);
        bus_a.cpu_iorq = 0; bus_a.cpu_rd = 0; bus_a.cpu_addr = 16'h4123; #1;
        checks++; if (bus_a.mapper_addr !== 22'h008123 || bus_a.mapper_req !== 1'b0) begin
            errors++; $display("FAIL xlat_4123 got=%h req=%b exp=008123 req=0", bus_a.mapper_addr, bus_a.mapper_req);
        end
        bus_a.cpu_addr = 16'h00FD; bus_a.cpu_iorq = 1; bus_a.cpu_rd = 1; bus_a.cpu_m1 = 1; #1;
        checks++; if (bus_a.mapper_req !== 1'b0) begin
            errors++; $display("FAIL req_m1 got=%b exp=0", bus_a.mapper_req);
        end
        bus_a.cpu_iorq = 0; bus_a.cpu_rd = 0; bus_a.cpu_m1 = 0;
    endtask

    task automatic test_edge_commit();
        int c0;
        c0 = commits_a;
        io_wr_a(8'hFE, 8'h07, 5, 1'b0);
        checks++; if (commits_a - c0 !== 1) begin
            errors++; $display("FAIL held_wr_commits got=%0d exp=1", commits_a - c0);
        end
        bus_a.cpu_addr = 16'h8005; #1;
        checks++; if (bus_a.mapper_addr !== 22'h01C005) begin
            errors++; $display("FAIL xlat_8005 got=%h exp=01c005", bus_a.mapper_addr);
        end
        c0 = commits_a;
        io_wr_a(8'hFE, 8'h0A, 2, 1'b1);
        bus_a.cpu_addr = 16'h8005; #1;
        checks++; if (commits_a - c0 !== 0 || bus_a.mapper_addr !== 22'h01C005) begin
            errors++; $display("FAIL m1_wr_ignored got commits=%0d addr=%h exp 0 01c005", commits_a - c0, bus_a.mapper_addr);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = commits_a;
        io_wr_a(8'hFC, 8'h05, 1, 1'b0);
        io_wr_a(8'hFD, 8'h06, 1, 1'b0);
        checks++; if (commits_a - c0 !== 2) begin
            errors++; $display("FAIL b2b_commits got=%0d exp=2", commits_a - c0);
        end
        bus_a.cpu_addr = 16'h0010; #1;
        checks++; if (bus_a.mapper_addr !== 22'h014010) begin
            errors++; $display("FAIL b2b_page0 got=%h exp=014010", bus_a.mapper_addr);
        end
        bus_a.cpu_addr = 16'h7FFF; #1;
        checks++; if (bus_a.mapper_addr !== 22'h01BFFF) begin
            errors++; $display("FAIL b2b_page1 got=%h exp=01bfff", bus_a.mapper_addr);
        end
    endtask

    task automatic test_readback();
        logic [7:0] exp_rd [4];
        exp_rd = '{8'hF7, 8'h07, 8'hFF, 8'hFF};
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            mode_a = 2'(m); bus_a.cpu_addr = 16'h00FE; bus_a.cpu_iorq = 1; bus_a.cpu_rd = 1; #1;
            checks++; if (bus_a.mapper_dout !== exp_rd[m]) begin
                errors++; $display("FAIL rb_mode%0d got=%h exp=%h", m, bus_a.mapper_dout, exp_rd[m]);
            end
        end
        @(negedge clk);
        mode_a = 2'd0; cnt_a = 9'd4; #1;
        checks++; if (bus_a.mapper_dout !== 8'hFF) begin
            errors++; $display("FAIL rb_or_cnt4 got=%h exp=ff", bus_a.mapper_dout);
        end
        bus_a.cpu_iorq = 0; bus_a.cpu_rd = 0; bus_a.cpu_addr = 16'h8000; #1;
        checks++; if (bus_a.mapper_addr !== 22'h00C000) begin
            errors++; $display("FAIL xlat_cnt4 got=%h exp=00c000", bus_a.mapper_addr);
        end
        cnt_a = 9'd16;
    endtask

    task automatic test_ext_hi();
        io_wr_b(8'hF7, 8'h02);
        io_wr_b(8'hFD, 8'h34);
        bus_b.cpu_addr = 16'h4000; #1;
        checks++; if (bus_b.mapper_addr !== 24'h8D0000) begin
            errors++; $display("FAIL ext_seg1 got=%h exp=8d0000", bus_b.mapper_addr);
        end
        cnt_b = 11'd0; #1;
        checks++; if (bus_b.mapper_addr !== 24'h8D0000) begin
            errors++; $display("FAIL ext_cnt0 got=%h exp=8d0000", bus_b.mapper_addr);
        end
        cnt_b = 11'd512; #1;
        checks++; if (bus_b.mapper_addr !== 24'h0D0000) begin
            errors++; $display("FAIL ext_cnt512 got=%h exp=0d0000", bus_b.mapper_addr);
        end
        cnt_b = 11'd1024;
        bus_b.cpu_addr = 16'h00FD; bus_b.cpu_iorq = 1; bus_b.cpu_rd = 1; #1;
        checks++; if (bus_b.mapper_dout !== 8'h34) begin
            errors++; $display("FAIL ext_rb_or got=%h exp=34", bus_b.mapper_dout);
        end
        bus_b.cpu_iorq = 0; bus_b.cpu_rd = 0;
        io_wr_b(8'hFD, 8'h01);
        bus_b.cpu_addr = 16'h4000; #1;
        checks++; if (bus_b.mapper_addr !== 24'h004000) begin
            errors++; $display("FAIL ext_cleared got=%h exp=004000", bus_b.mapper_addr);
        end
    endtask

    task automatic test_clear_sweep();
        int hs = 0;
        int bad = 0;
        int cyc = 0;
        bit done = 0;
        bit pulsed = 0;
        logic [21:0] exp_addr = '0;
        ack_c = 0; start_c = 0;
        @(negedge clk); rst_c = 1;
        @(negedge clk); #1;
        checks++; if (busy_c !== 1'b1 || req_c !== 1'b1 || iaddr_c !== 22'd0) begin
            errors++; $display("FAIL auto_start got busy=%b req=%b addr=%h exp 1 1 0", busy_c, req_c, iaddr_c);
        end
        while (!done && cyc < 40000) begin
            ack_c = (cyc % 2) == 1;
            start_c = (hs == 8000) && !pulsed;
            if (start_c) pulsed = 1;
            #1;
            if (req_c && ack_c) begin
                if (iaddr_c !== exp_addr) bad++;
                exp_addr++;
                hs++;
            end
            @(negedge clk);
            cyc++;
            if (!busy_c) done = 1;
        end
        ack_c = 0; start_c = 0;
        checks++; if (done !== 1'b1) begin
            errors++; $display("FAIL sweep_timeout got busy=%b exp busy=0 within 40000 clks", busy_c);
        end
        checks++; if (hs !== 16384) begin
            errors++; $display("FAIL sweep_len got=%0d exp=16384", hs);
        end
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL sweep_addr got %0d bad addresses exp=0", bad);
        end
        checks++; if (pulsed !== 1'b1) begin
            errors++; $display("FAIL busy_start_issued got=%b exp=1", pulsed);
        end
        ack_c = 1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (busy_c !== 1'b0 || req_c !== 1'b0) begin
            errors++; $display("FAIL idle_ack got busy=%b req=%b exp 0 0", busy_c, req_c);
        end
        ack_c = 0;
    endtask

    task automatic test_restart_abort();
        @(negedge clk); start_c = 1;
        @(negedge clk); start_c = 0; #1;
        checks++; if (busy_c !== 1'b1 || req_c !== 1'b1 || iaddr_c !== 22'd0) begin
            errors++; $display("FAIL restart got busy=%b req=%b addr=%h exp 1 1 0", busy_c, req_c, iaddr_c);
        end
        ack_c = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (iaddr_c !== 22'd3) begin
            errors++; $display("FAIL restart_advance got=%h exp=3", iaddr_c);
        end
        ack_c = 0; rst_c = 0; #1;
        checks++; if (req_c !== 1'b0 || iaddr_c !== 22'd0 || busy_c !== 1'b0) begin
            errors++; $display("FAIL abort got req=%b addr=%h busy=%b exp 0 0 0", req_c, iaddr_c, busy_c);
        end
        @(negedge clk); rst_c = 1;
        @(negedge clk); #1;
        checks++; if (busy_c !== 1'b1 || iaddr_c !== 22'd0) begin
            errors++; $display("FAIL reboot got busy=%b addr=%h exp 1 0", busy_c, iaddr_c);
        end
    endtask

    initial begin
        test_reset();
        test_reset_style();
        test_edge_commit();
        test_back_to_back();
        test_readback();
        test_ext_hi();
        test_clear_sweep();
        test_restart_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
